fetch_pc: RTL and testbench
===========================

FETCH_PC -- requirements
Module: fetch_pc

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, giving the PC and fetch address width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h2000_0000, giving the first fetch address after reset.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, range 1..8, giving the maximum number of issued requests still awaiting a response.
REQ-004 SHALL have the following ports: CLK  in  1  clock; all state changes on its rising edge.
REQ-005 SHALL have the following port: RST  in  1  synchronous, active-high reset.
REQ-006 SHALL have the following port: EXEC  in  1  run enable; new requests are issued only while high.
REQ-007 SHALL have the following port: STALL  in  1  decode stall; holds P_* outputs and deasserts RSP_READY.
REQ-008 SHALL have the following ports: FLUSH  in  1  redirect strobe; NEW_PC  in  ADDR_W  redirect target.
REQ-009 SHALL have the following ports: REQ_VALID  out  1, REQ_READY  in  1, REQ_ADDR  out  ADDR_W; together these form the fetch request handshake.
REQ-010 SHALL have the following ports: RSP_VALID  in  1, RSP_READY  out  1, RSP_DATA  in  32; together these form the in-order fetch response handshake.
REQ-011 SHALL have the following ports: P_PC  out  ADDR_W, P_INST  out  32, P_VALID  out  1; together these carry the instruction to decode.
REQ-012 SHALL have the following port: MISALIGN  out  1  sticky misaligned-redirect flag; present only when FETCH_MISALIGN_TRAP_EN is defined.

Function
REQ-013 SHALL hold a fetch PC register. REQ_ADDR SHALL equal this register combinationally.
REQ-014 SHALL drive REQ_VALID = EXEC & !FLUSH & !RST & (live_cnt + kill_cnt < MAX_OUTSTANDING), with MISALIGN low when that flag is present.
REQ-015 SHALL, on request fire (REQ_VALID & REQ_READY), advance the fetch PC by 4 modulo 2^ADDR_W. It SHALL also push the issued address into a PC FIFO of depth MAX_OUTSTANDING.
REQ-016 SHALL drive RSP_READY = !STALL.
REQ-017 SHALL, on response fire while kill_cnt > 0, decrement kill_cnt and discard RSP_DATA.
REQ-018 SHALL, on response fire while kill_cnt = 0 and the FIFO is non-empty, pop the FIFO. On the next edge it SHALL present P_PC = popped address, P_INST = RSP_DATA and P_VALID = 1 (1-cycle latency).
REQ-019 SHALL ignore a response fire that occurs while both the FIFO is empty and kill_cnt = 0; no state SHALL change.
REQ-020 SHALL hold P_PC, P_INST and P_VALID unchanged while STALL = 1 and FLUSH = 0.
REQ-021 SHALL set P_VALID to 0 when STALL = 0 and no live response fires.
REQ-022 SHALL, when a simultaneous push and pop occur on a full FIFO, complete both; the count SHALL remain unchanged.
REQ-023 SHALL, on FLUSH, perform the following on the next edge: fetch PC <= NEW_PC; FIFO cleared; P_VALID <= 0; kill_cnt <= kill_cnt + live_cnt - (1 if a response fires this cycle).
REQ-024 SHALL give FLUSH priority over STALL and EXEC. Back-to-back FLUSH cycles SHALL each retarget, and the last NEW_PC wins.
REQ-025 SHALL, while EXEC = 0, issue no requests. Outstanding responses SHALL still drain per REQ-017 and REQ-018.
REQ-026 SHALL keep live_cnt + kill_cnt <= MAX_OUTSTANDING at all times. The counter width SHALL be clog2(MAX_OUTSTANDING+1).

Reset
REQ-027 SHALL, on RST, set: fetch PC = RESET_VECTOR, P_PC = RESET_VECTOR, P_INST = 0, P_VALID = 0, FIFO empty, kill_cnt = 0 (and MISALIGN = 0 when present).
REQ-028 SHALL abandon in-flight requests when RST is asserted mid-operation; the memory side is reset by the same RST. The first request SHALL issue on the first cycle after RST falls if EXEC = 1.

Configuration
REQ-029 SHALL, with FETCH_MISALIGN_TRAP_EN defined, set MISALIGN = 1 on a FLUSH whose NEW_PC[1:0] != 0. Requests SHALL be blocked until a later FLUSH with NEW_PC[1:0] = 0, which clears MISALIGN.
REQ-030 SHALL, with FETCH_MISALIGN_TRAP_EN undefined, have no MISALIGN port and load the fetch PC with {NEW_PC[ADDR_W-1:2], 2'b00}.

Verification
REQ-031 SHALL cover sequential fetch: EXEC = 1, REQ_READY = 1, 1-cycle-delayed responses -> REQ_ADDR sequence 0x2000_0000, 0x2000_0004, 0x2000_0008 and matching P_PC/P_INST with P_VALID pulses.
REQ-032 SHALL cover the outstanding limit: REQ_READY = 1, RSP_VALID = 0 -> exactly 4 requests, then REQ_VALID = 0. One response fire -> a 5th request is issued.
REQ-033 SHALL cover flush with in-flight requests: 3 outstanding, FLUSH with NEW_PC = 0x2000_0100 -> the next 3 responses are dropped with P_VALID = 0, and the 4th response shows P_PC = 0x2000_0100.
REQ-034 SHALL cover stall: STALL = 1 for 5 cycles with P_VALID = 1 and RSP_VALID = 1 -> P_* held, RSP_READY = 0, and no FIFO pop occurs.
REQ-035 SHALL cover simultaneous events: FLUSH coinciding with a response fire and STALL = 1 -> the response is discarded, kill_cnt is correct, and P_VALID = 0 on the next edge.
REQ-036 SHALL cover a misaligned redirect: FLUSH with NEW_PC = 0x2000_0102 -> with the macro defined, MISALIGN = 1 and no requests are issued; without it, the next REQ_ADDR = 0x2000_0100.

Source files
------------

// File: rtl/fetch_pc.sv
// Instruction fetch PC generator: issues sequential fetch requests, tracks them in an
// in-order PC FIFO and pairs returning data with its address. Optional FETCH_MISALIGN_TRAP_EN.
module fetch_pc #(
    parameter int                 ADDR_W          = 32,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR    = ADDR_W'(32'h2000_0000),
    parameter int                 MAX_OUTSTANDING = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EXEC,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic [ADDR_W-1:0] NEW_PC,
    output logic              REQ_VALID,
    input  logic              REQ_READY,
    output logic [ADDR_W-1:0] REQ_ADDR,
    input  logic              RSP_VALID,
    output logic              RSP_READY,
    input  logic [31:0]       RSP_DATA,
    output logic [ADDR_W-1:0] P_PC,
    output logic [31:0]       P_INST,
    output logic              P_VALID
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic              MISALIGN
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_live_cnt;
    logic [CNT_W-1:0]  r_kill_cnt;
    logic [ADDR_W-1:0] r_p_pc;
    logic [31:0]       r_p_inst;
    logic              r_p_valid;

    logic [CNT_W:0]    w_inflight;
    logic [CNT_W:0]    w_flush_kill;
    logic              w_blocked;
    logic              w_req_valid;
    logic              w_req_fire;
    logic              w_rsp_fire;
    logic              w_kill_fire;
    logic              w_live_fire;
    logic              w_drop;
    logic [ADDR_W-1:0] w_redirect_pc;

    function automatic logic [PTR_W-1:0] ptrNext(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misalign;

    // A misaligned redirect parks the fetcher until an aligned redirect arrives.
    always_ff @(posedge CLK) begin
        if (RST)
            r_misalign <= 1'b0;
        else if (FLUSH)
            r_misalign <= |NEW_PC[1:0];
    end

    assign MISALIGN      = r_misalign;
    assign w_blocked     = r_misalign;
    assign w_redirect_pc = NEW_PC;
`else
    logic w_unused;

    assign w_unused      = ^NEW_PC[1:0];
    assign w_blocked     = 1'b0;
    assign w_redirect_pc = {NEW_PC[ADDR_W-1:2], 2'b00};
`endif

    assign w_inflight   = {1'b0, r_live_cnt} + {1'b0, r_kill_cnt};
    assign w_req_valid  = EXEC & ~FLUSH & ~RST & ~w_blocked
                        & (w_inflight < (CNT_W+1)'(MAX_OUTSTANDING));
    assign w_req_fire   = w_req_valid & REQ_READY;
    assign w_rsp_fire   = RSP_VALID & ~STALL;
    assign w_kill_fire  = w_rsp_fire & (r_kill_cnt != '0);
    assign w_live_fire  = w_rsp_fire & (r_kill_cnt == '0) & (r_live_cnt != '0);
    // A response arriving with nothing in flight is spurious and must not be counted.
    assign w_drop       = w_rsp_fire & (w_inflight != '0);
    assign w_flush_kill = w_inflight - (CNT_W+1)'(w_drop);

    assign REQ_VALID = w_req_valid;
    assign REQ_ADDR  = r_pc;
    assign RSP_READY = ~STALL;
    assign P_PC      = r_p_pc;
    assign P_INST    = r_p_inst;
    assign P_VALID   = r_p_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc       <= RESET_VECTOR;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_live_cnt <= '0;
            r_kill_cnt <= '0;
            r_p_pc     <= RESET_VECTOR;
            r_p_inst   <= '0;
            r_p_valid  <= 1'b0;
        end else if (FLUSH) begin
            // Everything still live becomes a response to be discarded on return.
            r_pc       <= w_redirect_pc;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_live_cnt <= '0;
            r_kill_cnt <= w_flush_kill[CNT_W-1:0];
            r_p_valid  <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_pc     <= r_pc + ADDR_W'(4);
                r_wr_ptr <= ptrNext(r_wr_ptr);
            end
            if (w_live_fire)
                r_rd_ptr <= ptrNext(r_rd_ptr);
            r_live_cnt <= r_live_cnt + CNT_W'(w_req_fire) - CNT_W'(w_live_fire);
            r_kill_cnt <= r_kill_cnt - CNT_W'(w_kill_fire);
            if (w_live_fire) begin
                r_p_pc    <= r_fifo[r_rd_ptr];
                r_p_inst  <= RSP_DATA;
                r_p_valid <= 1'b1;
            end else if (!STALL) begin
                r_p_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_req_fire)
            r_fifo[r_wr_ptr] <= r_pc;
    end

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: directed scenarios then randomized traffic, all
// compared against a queue-based model of the fetch unit and the memory behind it.
module tb_fetch_pc;

    localparam int          MAXO = 4;
    localparam logic [31:0] RV   = 32'h2000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EXEC = 1'b0;
    logic        STALL = 1'b0;
    logic        FLUSH = 1'b0;
    logic [31:0] NEW_PC = '0;
    logic        REQ_VALID;
    logic        REQ_READY = 1'b0;
    logic [31:0] REQ_ADDR;
    logic        RSP_VALID = 1'b0;
    logic        RSP_READY;
    logic [31:0] RSP_DATA = '0;
    logic [31:0] P_PC;
    logic [31:0] P_INST;
    logic        P_VALID;

    fetch_pc #(.ADDR_W(32), .RESET_VECTOR(RV), .MAX_OUTSTANDING(MAXO)) dut (
        .CLK(CLK), .RST(RST), .EXEC(EXEC), .STALL(STALL), .FLUSH(FLUSH), .NEW_PC(NEW_PC),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
        .P_PC(P_PC), .P_INST(P_INST), .P_VALID(P_VALID)
    );

    always #5 CLK = ~CLK;

    // Reference state: next fetch address, decode outputs, live addresses awaiting data,
    // responses to discard, and every request the memory still owes a response for.
    logic [31:0] mPc;
    logic [31:0] mPPc;
    logic [31:0] mPInst;
    logic        mPValid;
    logic [31:0] liveQ[$];
    logic [31:0] memQ[$];
    int          killCnt;
    int          testsRun = 0;
    int          failCount = 0;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyReset();
        @(negedge CLK);
        RST = 1'b1; EXEC = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
        REQ_READY = 1'b1; RSP_VALID = 1'b0;
        #1;
        checkOutput("rstReqValid", 32'(REQ_VALID), 32'd0);
        @(posedge CLK);
        mPc = RV; mPPc = RV; mPInst = '0; mPValid = 1'b0;
        liveQ.delete(); memQ.delete(); killCnt = 0;
        #1;
        checkOutput("rstReqAddr", REQ_ADDR, RV);
        checkOutput("rstPPc", P_PC, RV);
        checkOutput("rstPInst", P_INST, 32'd0);
        checkOutput("rstPValid", 32'(P_VALID), 32'd0);
    endtask

    // One clock of stimulus; the memory answers its oldest owed request when asked to respond.
    task automatic applyStimulus(input logic exec, input logic stall, input logic flush,
                                 input logic [31:0] newPc, input logic rdy, input logic rspWant);
        logic        expReqValid;
        logic        reqFire;
        logic        rspFire;
        logic [31:0] data;
        int          inflight;
        @(negedge CLK);
        RST = 1'b0; EXEC = exec; STALL = stall; FLUSH = flush; NEW_PC = newPc;
        REQ_READY = rdy; RSP_VALID = rspWant;
        data = (memQ.size() > 0) ? memData(memQ[0]) : $urandom;
        RSP_DATA = data;
        #1;
        inflight    = liveQ.size() + killCnt;
        expReqValid = exec && !flush && (inflight < MAXO);
        checkOutput("REQ_VALID", 32'(REQ_VALID), 32'(expReqValid));
        checkOutput("REQ_ADDR", REQ_ADDR, mPc);
        checkOutput("RSP_READY", 32'(RSP_READY), 32'(!stall));
        reqFire = expReqValid && rdy;
        rspFire = rspWant && !stall;
        if (rspFire && memQ.size() > 0)
            void'(memQ.pop_front());
        if (flush) begin
            killCnt = inflight - ((rspFire && inflight > 0) ? 1 : 0);
            liveQ.delete();
            mPc = {newPc[31:2], 2'b00};
            mPValid = 1'b0;
        end else begin
            if (rspFire && killCnt > 0) begin
                killCnt--;
                if (!stall) mPValid = 1'b0;
            end else if (rspFire && liveQ.size() > 0) begin
                mPPc = liveQ.pop_front();
                mPInst = data;
                mPValid = 1'b1;
            end else if (!stall) begin
                mPValid = 1'b0;
            end
            if (reqFire) begin
                liveQ.push_back(mPc);
                memQ.push_back(mPc);
                mPc = mPc + 32'd4;
            end
        end
        @(posedge CLK);
        #1;
        checkOutput("P_VALID", 32'(P_VALID), 32'(mPValid));
        checkOutput("P_PC", P_PC, mPPc);
        checkOutput("P_INST", P_INST, mPInst);
    endtask

    initial begin
        applyReset();

        // Sequential fetch with responses one cycle behind requests.
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, '0, 1, 1);

        // Outstanding limit: four requests then stop; one response frees a slot.
        applyReset();
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, '0, 1, 0);
        checkOutput("limitHold", 32'(REQ_VALID), 32'd0);
        applyStimulus(1, 0, 0, '0, 1, 1);
        applyStimulus(1, 0, 0, '0, 1, 0);
        checkOutput("limitFifthAddr", REQ_ADDR, RV + 32'd20);

        // Flush with three requests in flight; the stale responses are dropped.
        applyReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, '0, 1, 0);
        applyStimulus(1, 0, 1, 32'h2000_0100, 1, 0);
        checkOutput("flushAddr", REQ_ADDR, 32'h2000_0100);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, '0, 1, 1);

        // Stall holding a valid instruction while the memory keeps offering data.
        applyReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, '0, 1, 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, '0, 1, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, '0, 1, 1);

        // Flush coinciding with a response, with and without stall.
        applyReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, '0, 1, 0);
        applyStimulus(1, 0, 0, '0, 1, 1);
        applyStimulus(1, 1, 1, 32'h2000_0200, 1, 1);
        applyStimulus(1, 0, 1, 32'h2000_0300, 1, 1);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, '0, 1, 1);

        // Misaligned redirect, then back-to-back flushes where the last target wins.
        applyStimulus(1, 0, 1, 32'h2000_0102, 1, 0);
        checkOutput("misalignAddr", REQ_ADDR, 32'h2000_0100);
        applyStimulus(1, 0, 1, 32'h2000_0400, 1, 1);
        applyStimulus(1, 0, 1, 32'h2000_0500, 1, 1);
        checkOutput("lastFlushWins", REQ_ADDR, 32'h2000_0500);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, '0, 1, 1);

        // Randomized traffic, including mid-run resets and spurious responses.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 2)
                applyReset();
            else
                applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2,
                              $urandom_range(0, 19) == 0,
                              RV + 32'($urandom_range(0, 1023)),
                              $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
